// File: rtl/bram_arbiter.sv
// bram_arbiter
//   Round-robin arbiter for two requesters sharing one single-port bram
//   (registered output, one-cycle read latency at the bram).
//   Each requester has a req/ack command handshake and a tagged read-return
//   path. The command and the return path are fully pipelined and never stall.
//
// Ports
//   clk, reset                 system clock, async active-high reset
//   req/rw/addr/wdata (0,1)    command request, type (0=read 1=write), payload
//   ack (0,1)                  one-cycle pulse: command accepted
//   rvalid/rdata (0,1)         one-cycle pulse plus held read data
//   mem_data/mem_readWrite/mem_addr   command to the bram
//   mem_out                    bram registered read data
module bram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_readWrite,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_out
);

    logic              elig0;
    logic              elig1;
    logic              grant_any;
    logic              grant_port;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Port most recently granted; the other port wins a tie.
    logic              last_port;

    // Read-return tags: stage 1 follows the issue, stage 2 lines up with
    // the bram output becoming valid.
    logic              tag1_valid;
    logic              tag1_port;
    logic              tag2_valid;
    logic              tag2_port;

    always_comb begin
        // A port whose ack is high this cycle is still holding the
        // request it just had accepted, so it is masked out.
        elig0     = req0 & ~ack0;
        elig1     = req1 & ~ack1;
        grant_any = elig0 | elig1;
        if (elig0 && elig1) begin
            grant_port = ~last_port;
        end else begin
            grant_port = elig1;
        end
        if (grant_port) begin
            sel_rw    = rw1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end else begin
            sel_rw    = rw0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end
    end

    // Issue stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            mem_readWrite <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            last_port     <= 1'b1;
            tag1_valid    <= 1'b0;
            tag1_port     <= 1'b0;
        end else begin
            ack0          <= grant_any & ~grant_port;
            ack1          <= grant_any & grant_port;
            // Idle cycles fall back to a read so a write is never repeated.
            mem_readWrite <= 1'b0;
            tag1_valid    <= 1'b0;
            if (grant_any) begin
                last_port     <= grant_port;
                mem_readWrite <= sel_rw;
                mem_addr      <= sel_addr;
                mem_data      <= sel_wdata;
                tag1_valid    <= ~sel_rw;
                tag1_port     <= grant_port;
            end
        end
    end

    // Return stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag2_valid <= 1'b0;
            tag2_port  <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            tag2_valid <= tag1_valid;
            tag2_port  <= tag1_port;
            rvalid0    <= tag2_valid & ~tag2_port;
            rvalid1    <= tag2_valid & tag2_port;
            if (tag2_valid && !tag2_port) begin
                rdata0 <= mem_out;
            end
            if (tag2_valid && tag2_port) begin
                rdata1 <= mem_out;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: behavioural bram, transaction-level reference
// model (shadow memory + timed return queue), directed and random stimulus.
module tb_bram_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, rw0, req1, rw1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, rvalid0, ack1, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_data, mem_addr;
    logic       mem_readWrite;
    logic [7:0] bram_out;
    logic [7:0] bram_mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_data(mem_data), .mem_readWrite(mem_readWrite),
        .mem_addr(mem_addr), .mem_out(bram_out)
    );

    // Single-port bram: registered out, out reads 0 after a write.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) bram_mem[i] <= 8'(255 - i);
            bram_out <= '0;
        end else if (mem_readWrite) begin
            bram_mem[mem_addr] <= mem_data;
            bram_out <= '0;
        end else begin
            bram_out <= bram_mem[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        bit       port;
        bit [7:0] data;
    } ret_t;

    ret_t     rq[$];
    bit [7:0] shadow [256];
    int       cyc;
    bit       last_win;
    bit       e_ack0, e_ack1, e_rv0, e_rv1, e_rw;
    bit [7:0] e_rd0, e_rd1, e_addr, e_data;

    task automatic model_reset();
        rq.delete();
        for (int i = 0; i < 256; i++) shadow[i] = 8'(255 - i);
        last_win = 1'b1;
        e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0; e_rw = 0;
        e_rd0 = 0; e_rd1 = 0; e_addr = 0; e_data = 0;
    endtask

    // Called right after each rising edge with the inputs that edge saw.
    task automatic model_edge();
        bit   el0, el1, w, any, rw;
        bit [7:0] a, d;
        ret_t r;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        el0 = req0 && !e_ack0;
        el1 = req1 && !e_ack1;
        any = el0 || el1;
        w   = (el0 && el1) ? !last_win : el1;
        e_rv0 = 0;
        e_rv1 = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.port) begin e_rv1 = 1; e_rd1 = r.data; end
            else        begin e_rv0 = 1; e_rd0 = r.data; end
        end
        e_ack0 = any && !w;
        e_ack1 = any && w;
        e_rw   = 0;
        if (any) begin
            last_win = w;
            rw = w ? rw1 : rw0;
            a  = w ? addr1 : addr0;
            d  = w ? wdata1 : wdata0;
            e_rw = rw; e_addr = a; e_data = d;
            if (rw) shadow[a] = d;
            else    rq.push_back('{due: cyc + 2, port: w, data: shadow[a]});
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("ack0", 32'(ack0), 32'(e_ack0));
        check("ack1", 32'(ack1), 32'(e_ack1));
        check("rvalid0", 32'(rvalid0), 32'(e_rv0));
        check("rvalid1", 32'(rvalid1), 32'(e_rv1));
        check("rdata0", 32'(rdata0), 32'(e_rd0));
        check("rdata1", 32'(rdata1), 32'(e_rd1));
        check("mem_readWrite", 32'(mem_readWrite), 32'(e_rw));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_data", 32'(mem_data), 32'(e_data));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int acks;

    initial begin
        rst = 1'b1;
        req0 = 0; rw0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; rw1 = 0; addr1 = 0; wdata1 = 0;
        cyc = 0;
        model_reset();
        step();
        step();
        check("reset_ack0", 32'(ack0), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Port 0 reads 0x10
        req0 = 1; rw0 = 0; addr0 = 8'h10;
        step();
        check("tp1_ack0", 32'(ack0), 32'd1);
        req0 = 0;
        step();
        step();
        check("tp1_rvalid0", 32'(rvalid0), 32'd1);
        check("tp1_rdata0", 32'(rdata0), 32'hEF);
        check("tp1_rvalid1", 32'(rvalid1), 32'd0);

        // Port 1 writes 0x5A to 0x03 then reads it back
        req1 = 1; rw1 = 1; addr1 = 8'h03; wdata1 = 8'h5A;
        step();
        check("tp2_ack1_wr", 32'(ack1), 32'd1);
        rw1 = 0;
        step();
        check("tp2_ack1_mask", 32'(ack1), 32'd0);
        step();
        check("tp2_ack1_rd", 32'(ack1), 32'd1);
        req1 = 0;
        step();
        step();
        check("tp2_rdata1", 32'(rdata1), 32'h5A);
        check("tp2_rvalid1", 32'(rvalid1), 32'd1);

        // Both ports read continuously
        req0 = 1; rw0 = 0; addr0 = 8'h00;
        req1 = 1; rw1 = 0; addr1 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step();
            check("tp3_alt_ack0", 32'(ack0), 32'((i % 2) == 0));
        end
        req0 = 0; req1 = 0;
        step();
        check("tp3_rdata1", 32'(rdata1), 32'h00);
        step();
        check("tp3_rdata0", 32'(rdata0), 32'hFF);

        // Write by port 0 then read by port 1 the next cycle
        req0 = 1; rw0 = 1; addr0 = 8'h20; wdata0 = 8'h77;
        step();
        req0 = 0;
        req1 = 1; rw1 = 0; addr1 = 8'h20;
        step();
        req1 = 0;
        step();
        step();
        check("tp4_rdata1", 32'(rdata1), 32'h77);

        // Reset between ack and rvalid
        req0 = 1; rw0 = 0; addr0 = 8'h05;
        step();
        req0 = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("tp5_rdata1_zero", 32'(rdata1), 32'd0);
        step();
        @(negedge clk) rst = 1'b0;
        step();
        step();
        check("tp5_no_rvalid0", 32'(rvalid0), 32'd0);
        req0 = 1; rw0 = 0; addr0 = 8'h20;
        step();
        req0 = 0;
        step();
        step();
        check("tp5_rdata0", 32'(rdata0), 32'hDF);

        // req0 held alone for 6 cycles
        req0 = 1; rw0 = 0; addr0 = 8'h40;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack0) acks++;
            if (!ack0) check("tp6_idle_read", 32'(mem_readWrite), 32'd0);
        end
        check("tp6_ack_count", 32'(acks), 32'd3);
        req0 = 0;
        step();
        step();

        // Random traffic on a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if (!req0 || e_ack0) begin
                req0 = 1'($urandom_range(0, 1));
                rw0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom_range(0, 7));
                wdata0 = 8'($urandom);
            end
            if (!req1 || e_ack1) begin
                req1 = 1'($urandom_range(0, 1));
                rw1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom_range(0, 7));
                wdata1 = 8'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                addr1 = 8'($urandom_range(0, 7));
                wdata1 = 8'($urandom);
            end
            step();
        end
        req0 = 0; req1 = 0;
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester, round-robin arbiter that shares the single-port 256x8 bram.
- The bram interface is `data`, `readWrite` (0=read, 1=write), `addr` and a registered `out`.
- Each requester gets a req/ack command handshake and a tagged, registered read-return path.
- Sits between the bram and its two client blocks; the bram instance connects directly to the `mem_*` ports.

Parameters:
DATA_W, 8, data width of bram words and request payloads
ADDR_W, 8, bram address width (256 entries)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 command request, held until ack0 seen
rw0  input  1  port 0 command type, 0=read 1=write
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
ack0  output  1  one-cycle pulse: port 0 command accepted
rvalid0  output  1  one-cycle pulse: rdata0 holds port 0 read result
rdata0  output  DATA_W  port 0 read data, held until next port 0 read return
req1, rw1, addr1, wdata1, ack1, rvalid1, rdata1  (same widths and meanings for port 1)
mem_data  output  DATA_W  to bram data
mem_readWrite  output  1  to bram readWrite
mem_addr  output  ADDR_W  to bram addr
mem_out  input  DATA_W  from bram out; valid one edge after a read is sampled

Behaviour:
- Reset (async, active-high) drives these values:
  - ack0/1=0, rvalid0/1=0, rdata0/1=0.
  - mem_readWrite=0, mem_addr=0, mem_data=0.
  - Pipeline tags cleared; round-robin pointer set so port 0 wins the first tie.
- Eligibility: port k is eligible at an edge iff reqk=1 and ackk=0 at that edge.
  - The ack mask prevents a held req being issued twice.
  - A single port can therefore issue at most every other cycle.
- Arbitration at each edge:
  - One eligible port: it wins.
  - Both eligible: the port not granted most recently wins.
  - Pointer updates only on a grant.
  - Neither eligible: no grant, pointer unchanged.
- Issue at edge N (all outputs registered):
  - mem_addr/mem_readWrite/mem_data <= winner's addr/rw/wdata.
  - ack(winner) <= 1 for exactly one cycle.
  - Stage-1 tag <= {valid = (rw==0), port}.
- Idle cycles: mem_readWrite <= 0 (read); mem_addr and mem_data hold their previous values.
  - Idle reads are harmless because they produce no tag.
  - A write must never be driven for more than the one granted cycle.
- Read return timing:
  - bram samples the command at edge N+1; stage-2 tag <= stage-1 tag.
  - At edge N+2, if stage-2 valid: rdata(port) <= mem_out and rvalid(port) <= 1 for one cycle.
  - The other port's rdata is unchanged.
- Latency: req sampled at edge N → ack high after N, rvalid high after N+2.
- Throughput: one command per cycle total when both ports request continuously; grants alternate 0,1,0,1.
- Writes produce no rvalid. bram `out` reads 0 after a write; mem_out is ignored for untagged cycles.
- Ordering and hazards:
  - Commands complete to the bram in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
- Pipeline: three commands may be in flight (issue, stage-1, stage-2); no stalls, no back-pressure on the return path.
- Reset mid-operation: in-flight reads are dropped (no rvalid) and pending acks are cleared. Requesters re-issue after reset.
  - The system wires the same reset to the bram, which reloads mem[i]=255-i.
- Payload sampling: only the winner's payload is sampled; a losing port's payload may change freely while req is held.

Test Plan:
- Reset, then port 0 reads addr 0x10 → ack0 pulses after edge 1; rvalid0=1, rdata0=0xEF after edge 3; rvalid1 stays 0.
- Port 1 writes 0x5A to addr 0x03, then reads addr 0x03 → ack1 twice, two cycles apart (ack mask); rvalid1 with rdata1=0x5A; no rvalid for the write.
- Both ports continuously read (port 0 at 0x00, port 1 at 0xFF) for 8 cycles → grants alternate, port 0 first; returns alternate rdata0=0xFF, rdata1=0x00, one per cycle after 2-cycle latency.
- Port 0 writes 0x77 to addr 0x20 and port 1 reads 0x20 in the next cycle → rdata1=0x77.
- Port 0 read issued, reset asserted between ack and rvalid → no rvalid0; all outputs 0. After release, a read of addr 0x20 returns 0xDF (bram reset restored).
- req0 held high with no other traffic for 6 cycles → ack0 pulses on alternate cycles (3 pulses); mem_readWrite=0 on idle cycles.
